// File: rtl/pitch_stabilizer.sv
// Pitch stabilizer: filters raw FFT peak-bin indices so the display only
// sees a new pitch after HOLD consecutive frames agree within TOL bins,
// then converts the published bin to Hz (Q8 scale, rounded, saturated).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a frame; in_ready high; silence-maps the bin
// CMP   | agreement check against candidate, hold count update
// MUL   | bin x Hz-per-bin product; remember published bin
// RND   | round/saturate to Hz, present on the output handshake
module pitch_stabilizer #(
  parameter int BW            = 10,
  parameter int HOLD          = 4,
  parameter int TOL           = 1,
  parameter int MIN_BIN       = 2,
  parameter int HZ_PER_BIN_Q8 = 12000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [BW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] out_bin,
  output logic [15:0]   out_hz,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = $clog2(HOLD + 1);
  localparam int PW = BW + 16;
  localparam logic [PW-1:0] HZ_K = PW'(HZ_PER_BIN_Q8);

  typedef enum logic [1:0] {IDLE, CMP, MUL, RND} state_t;

  state_t        state;
  logic [BW-1:0] cand;
  logic [BW-1:0] last_pub;
  logic [BW-1:0] bin_r;
  logic [CW-1:0] cnt;
  logic [PW-1:0] prod;

  logic [BW-1:0] diff;
  logic          agree;
  logic          publish;
  logic [CW-1:0] cnt_next;
  logic [PW:0]   rounded;
  logic [PW:0]   shifted;
  logic [15:0]   hz_sat;

  // Agreement and hold-count decision for the frame held in bin_r.
  // Silence only agrees with silence, so a tiny bin never merges with 0.
  always_comb begin
    diff     = (bin_r >= cand) ? (bin_r - cand) : (cand - bin_r);
    agree    = ((bin_r == '0) && (cand == '0)) ||
               ((bin_r != '0) && (cand != '0) && (diff <= BW'(TOL)));
    cnt_next = CW'(1);
    if (agree)
      cnt_next = (cnt == CW'(HOLD)) ? cnt : cnt + 1'b1;
    // Publish only on the HOLD-1 -> HOLD step, so a saturated count never republishes.
    publish  = agree && (cnt == CW'(HOLD - 1)) && (cand != last_pub);
  end

  // Q8 to integer Hz with round-half-up, clamped to the 16-bit display range.
  always_comb begin
    rounded = {1'b0, prod} + (PW+1)'(128);
    shifted = rounded >> 8;
    hz_sat  = (shifted > (PW+1)'(65535)) ? 16'hFFFF : shifted[15:0];
  end

  // Sequencer with registered handshake and published outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      cand      <= '0;
      cnt       <= '0;
      last_pub  <= '0;
      bin_r     <= '0;
      prod      <= '0;
      out_bin   <= '0;
      out_hz    <= '0;
      out_valid <= 1'b0;
    end else begin
      // Consumer handshake; a same-edge publish below overrides this clear.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (in_valid) begin
            bin_r    <= (in_data < BW'(MIN_BIN)) ? '0 : in_data;
            in_ready <= 1'b0;
            state    <= CMP;
          end
        end
        CMP: begin
          cnt <= cnt_next;
          if (!agree)
            cand <= bin_r;
          if (publish) begin
            state <= MUL;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        MUL: begin
          prod     <= PW'(cand) * HZ_K;
          last_pub <= cand;
          state    <= RND;
        end
        RND: begin
          out_hz    <= hz_sat;
          out_bin   <= last_pub;
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_stabilizer.sv
// Bench for pitch_stabilizer: directed vector table, hand-written corner
// sequences (backpressure/overwrite, held in_valid, mid-frame reset) and a
// randomized run against a frame-level reference model.
module tb_pitch_stabilizer;

  logic       clk;
  logic       reset_n;
  logic [9:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] out_bin;
  logic [15:0] out_hz;
  logic       out_valid;
  logic       out_ready;

  int checks;
  int failures;

  // reference model state (frame level)
  int m_cand;
  int m_cnt;
  int m_last;
  int m_bin;
  int m_hz;

  typedef struct {
    int bin;
    bit pub;
    int ob;
    int hz;
  } vec_t;

  vec_t tbl[$];

  pitch_stabilizer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bin   (out_bin),
    .out_hz    (out_hz),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int hz_of(input int bin);
    int v;
    v = (bin * 12000 + 128) / 256;
    return (v > 65535) ? 65535 : v;
  endfunction

  // Spec rules applied to one accepted frame; returns whether it publishes.
  task automatic model_step(input int raw, output bit pub);
    int  b;
    int  d;
    bit  ag;
    b   = (raw < 2) ? 0 : raw;
    d   = (b > m_cand) ? b - m_cand : m_cand - b;
    ag  = (b == 0 && m_cand == 0) || (b != 0 && m_cand != 0 && d <= 1);
    pub = 1'b0;
    if (ag) begin
      if (m_cnt == 3 && m_cand != m_last) pub = 1'b1;
      if (m_cnt < 4) m_cnt++;
    end else begin
      m_cand = b;
      m_cnt  = 1;
    end
    if (pub) begin
      m_last = m_cand;
      m_bin  = m_cand;
      m_hz   = hz_of(m_cand);
    end
  endtask

  task automatic model_reset();
    m_cand = 0; m_cnt = 0; m_last = 0; m_bin = 0; m_hz = 0;
  endtask

  // Offer one frame, wait for acceptance, then measure busy time:
  // in_ready back after 1 cycle = no publish, after 3 cycles = publish.
  task automatic send_frame(input int bin, input bit keep, output bit pub);
    int n;
    in_data  = 10'(bin);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    chk("ready_low_after_accept", int'(in_ready), 0);
    if (!keep) in_valid = 1'b0;
    n = 1;
    while (!in_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (n != 2 && n != 4) chk("busy_cycles", n - 1, 3);
    pub = (n == 4);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #17;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit pub;
    bit epub;
    int base;
    int b;

    checks = 0; failures = 0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1; reset_n = 1'b1;
    model_reset();
    #3;
    do_reset();

    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bin", int'(out_bin), 0);
    chk("rst_out_hz", int'(out_hz), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 1'b0, 0, 0});
    for (int i = 0; i < 3; i++) tbl.push_back('{10, 1'b0, 0, 0});
    tbl.push_back('{10, 1'b1, 10, 469});
    tbl.push_back('{10, 1'b0, 10, 469});
    tbl.push_back('{10, 1'b0, 10, 469});
    tbl.push_back('{20, 1'b0, 10, 469});
    tbl.push_back('{21, 1'b0, 10, 469});
    tbl.push_back('{19, 1'b0, 10, 469});
    tbl.push_back('{20, 1'b1, 20, 938});
    for (int i = 0; i < 10; i++) begin
      tbl.push_back('{30, 1'b0, 20, 938});
      tbl.push_back('{40, 1'b0, 20, 938});
    end
    for (int i = 0; i < 4; i++) tbl.push_back('{20, 1'b0, 20, 938});
    tbl.push_back('{1, 1'b0, 20, 938});
    tbl.push_back('{0, 1'b0, 20, 938});
    tbl.push_back('{1, 1'b0, 20, 938});
    tbl.push_back('{1, 1'b1, 0, 0});

    foreach (tbl[i]) begin
      send_frame(tbl[i].bin, 1'b0, pub);
      chk($sformatf("tbl%0d_pub", i), int'(pub), int'(tbl[i].pub));
      chk($sformatf("tbl%0d_out_bin", i), int'(out_bin), tbl[i].ob);
      chk($sformatf("tbl%0d_out_hz", i), int'(out_hz), tbl[i].hz);
      if (tbl[i].pub) chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), 1);
    end

    // ---------------- backpressure and overwrite ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(10, 1'b0, pub);
    chk("bp_pub10", int'(pub), 1);
    chk("bp_valid10", int'(out_valid), 1);
    chk("bp_bin10", int'(out_bin), 10);
    // in_valid held high across frames: in_ready must drop while busy
    for (int i = 0; i < 4; i++) begin
      send_frame(30, (i < 3), pub);
      chk("bp_valid_held", int'(out_valid), 1);
    end
    chk("bp_pub30", int'(pub), 1);
    chk("bp_bin30", int'(out_bin), 30);
    chk("bp_hz30", int'(out_hz), 1406);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_valid_pending", int'(out_valid), 1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_valid_dropped", int'(out_valid), 0);
    chk("bp_bin_kept", int'(out_bin), 30);

    // ---------------- reset mid-frame ----------------
    for (int i = 0; i < 4; i++) send_frame(10, 1'b0, pub);
    chk("mr_pub10", int'(pub), 1);
    chk("mr_valid_before", int'(out_valid), 1);
    in_data = 10'd50; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("mr_out_valid", int'(out_valid), 0);
    chk("mr_out_bin", int'(out_bin), 0);
    chk("mr_out_hz", int'(out_hz), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_in_ready", int'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("mr_no_publish", int'(out_valid), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_frame(0, 1'b0, pub);
      chk("mr_zero_nopub", int'(pub), 0);
    end
    chk("mr_zero_valid", int'(out_valid), 0);

    // ---------------- randomized run vs model ----------------
    do_reset();
    model_reset();
    base = 10;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0: base = 0;
          1: base = 1;
          2: base = 1023;
          default: base = $urandom_range(2, 1023);
        endcase
      end
      b = base + $urandom_range(0, 2) - 1;
      if (b < 0) b = 0;
      if (b > 1023) b = 1023;
      out_ready = 1'($urandom_range(0, 1));
      send_frame(b, 1'($urandom_range(0, 1)), pub);
      model_step(b, epub);
      chk($sformatf("rnd%0d_pub", i), int'(pub), int'(epub));
      chk($sformatf("rnd%0d_out_bin", i), int'(out_bin), m_bin);
      chk($sformatf("rnd%0d_out_hz", i), int'(out_hz), m_hz);
      if (epub) chk($sformatf("rnd%0d_out_valid", i), int'(out_valid), 1);
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pitch_stabilizer.md
# pitch_stabilizer

Sits between the FFT pitch detector and the HEX display driver. It consumes the stream of raw peak-bin indices (`dstream`, `$clog2(NSamples)` bits wide) and suppresses frame-to-frame jitter and octave flicker. A new pitch is published only after `HOLD` consecutive frames agree within `TOL` bins. Published bins are converted to Hz with fixed-point rounding, and the result is presented on a valid/ready output that the display consumes.

## Interface
- `BW`, 10, bin-index width (= `$clog2(NSamples)`)
- `HOLD`, 4, consecutive agreeing frames required before publish (≥2)
- `TOL`, 1, max |bin − candidate| counted as agreement
- `MIN_BIN`, 2, bins below this are treated as silence (bin 0)
- `HZ_PER_BIN_Q8`, 12000, Hz per bin in Q8 (48 kHz / 1024 = 46.875 → 12000)
- `clk`  in  1  system clock (`adc_clk` domain)
- `reset_n`  in  1  asynchronous, active-low reset
- `in_data`  in  BW  raw peak-bin index from the pitch detector
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block can accept a frame
- `out_bin`  out  BW  published stable bin
- `out_hz`  out  16  published pitch in Hz, rounded and saturated
- `out_valid`  out  1  new published value pending
- `out_ready`  in  1  consumer accepts the published value

## Operation
- Registers:
  - `cand` (BW)
  - `cnt` (0..HOLD, saturating)
  - `last_pub` (BW)
  - `prod` (BW+16)
  - `bin_r`
- FSM states: IDLE, CMP, MUL, RND.
- **IDLE.** `in_ready`=1. On `in_valid`: `bin_r` ← (`in_data` < `MIN_BIN`) ? 0 : `in_data`. Go to CMP.
- **CMP.**
  - Agreement: if `bin_r`==0 and `cand`==0, or both are nonzero and |`bin_r` − `cand`| ≤ `TOL`, then `cnt` ← min(`cnt`+1, `HOLD`) and `cand` is unchanged (no drift).
  - Otherwise `cand` ← `bin_r` and `cnt` ← 1.
  - Publish condition: `cnt` transitions `HOLD`−1 → `HOLD` and `cand` ≠ `last_pub`. If met, go to MUL; else go to IDLE.
- **MUL.** `prod` ← `cand` × `HZ_PER_BIN_Q8`. `last_pub` ← `cand`. Go to RND.
- **RND.**
  - `out_hz` ← min((`prod`+128)>>8, 65535).
  - `out_bin` ← `last_pub`.
  - `out_valid` ← 1.
  - Go to IDLE.
- **Output handshake.** `out_valid` falls on the cycle after `out_valid`&&`out_ready`. If a new publish occurs while `out_valid` is still high, `out_bin`/`out_hz` are overwritten (latest wins). The block never stalls on the output. `out_ready` low never blocks input.
- **Saturated count.** Once `cnt`==`HOLD`, further agreeing frames produce no republish.
- **Silence.** Silence publishes `out_bin`=0, `out_hz`=0.

## Timing
- **Reset (async, `reset_n` low).**
  - FSM enters IDLE.
  - `in_ready`=1 once `reset_n` is high.
  - `out_valid`=0, `out_bin`=0, `out_hz`=0.
  - `cand`=0, `cnt`=0, `last_pub`=0.
  - Reset mid-CMP/MUL/RND abandons the frame with no publish.
- **Input.** Frames are accepted only when `in_valid`&&`in_ready`; a source seeing `in_ready`=0 holds its data. Throughput is one frame per 2 cycles without publish, or 4 cycles with publish. FFT frames arrive far slower than this.
- **Latency.** The accepting edge is t0. CMP runs at t1, MUL at t2, RND at t3. `out_valid`/`out_bin`/`out_hz` are updated at edge t3 and visible from t3. `in_ready` is high again from t3 (publish) or t1 (no publish).
- **Simultaneous update and handshake.** If RND updates on the same edge that `out_valid`&&`out_ready` is sampled, `out_valid` stays 1 (the new value is pending).
- **Arithmetic width.** `prod` is BW+16 bits. With the defaults the maximum is 1023×12000 = 12,276,000, giving 47953 Hz, so no saturation occurs. The saturation path is still required for other parameter values.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-stream → `out_valid`=0, `out_bin`=0, `out_hz`=0 immediately. After release, `in_ready`=1 and the first 4 frames of bin 0 publish nothing (`last_pub`=0).
- **Basic publish.** Four frames of bin 10 → exactly one `out_valid` three cycles after the 4th acceptance, with `out_bin`=10 and `out_hz`=469. A 5th and 6th frame of bin 10 → no new `out_valid`.
- **Jitter tolerance.** From stable 10, feed 20, 21, 19, 20 → publish `out_bin`=20, `out_hz`=938 (`cand` stays 20).
- **Flicker.** Alternate 30, 40 for 20 frames → no publish; `out_bin` stays at its prior value.
- **Silence.** From stable 20, feed bins 1, 0, 1, 1 → publish `out_bin`=0, `out_hz`=0.
- **Backpressure and overwrite.** Hold `out_ready`=0; publish 10, then 30 → `out_valid` stays high with `out_bin`=30, `out_hz`=1406 and `in_ready` unaffected. Raise `out_ready` for one cycle → `out_valid`=0 on the next cycle. Also check `in_ready`=0 during CMP/MUL/RND while `in_valid` is held high, and that no frame is lost.
